motor_step_sequencer: RTL
=========================

// Module: motor_step_sequencer
// PURPOSE
// - Control-step front end for the downsampled motor NN wrapper. Runs at clk_1, upstream of motor_main.
// - Every PERIOD cycles it latches r/pos/vel and pulses ap_start + fc0_input_ap_vld.
// - Then waits for ap_done and captures layer13_out as the new motor command.
// - Guards the step with a watchdog, and counts overruns when a step tick lands while an inference is in flight.
// PARAMETERS
// - W         32    data width of r/pos/vel/command
// - PERIOD    1000  clk_1 cycles per control step (>=8)
// - TIMEOUT   900   max clk_1 cycles in WAIT before abort (< PERIOD)
// - CLAMP     32'sh0000_7FFF  symmetric clamp magnitude for latched inputs (CLAMP build only)
// PORTS
// - clk_1              in   1   single clock, all logic on posedge
// - ap_rst_n           in   1   synchronous reset, active low
// - en                 in   1   step timer enable
// - r_in,pos_in,vel_in in   W   live setpoint/position/velocity samples (signed)
// - r,pos,vel          out  W   latched samples to motor_main
// - ap_start           out  1   step start pulse to motor_main
// - fc0_input_ap_vld   out  1   input-valid pulse to motor_main, coincident with ap_start
// - ap_done            in   1   1-cycle done pulse from motor_main
// - layer13_out        in   W   NN command from motor_main
// - layer13_out_ap_vld in   1   command valid from motor_main (may stay high >1 clk_1)
// - u_out              out  W   last captured command (signed)
// - u_vld              out  1   1-cycle pulse: u_out updated this step
// - busy               out  1   high in LAUNCH/WAIT
// - timeout_flag       out  1   sticky: a step was aborted by the watchdog
// - overrun_cnt        out  16  dropped-tick count, saturating
// - clr_flags          in   1   clears timeout_flag and overrun_cnt
// BEHAVIOUR
// - Reset (ap_rst_n=0 at posedge): state=IDLE, every output 0, counters 0.
//   Reset mid-step aborts the step with no u_vld.
// - Step timer: tcnt counts 0..PERIOD-1 while en=1; tick=1 when tcnt==PERIOD-1, then wraps to 0.
//   en=0 holds tcnt at 0 and produces no ticks; an in-flight step still completes.
// - FSM IDLE -> LAUNCH -> WAIT -> IDLE:
//   - IDLE: on tick, latch r/pos/vel from *_in and go to LAUNCH.
//     Latched values appear 1 cycle after the tick and hold until the next latch.
//   - LAUNCH (exactly 1 cycle): ap_start=1 and fc0_input_ap_vld=1.
//     motor_main edge-detects both, so a 1-cycle pulse is sufficient. Next state WAIT; wdog cleared to 0.
//   - WAIT: wdog increments each cycle.
//     - A rising edge of layer13_out_ap_vld (vs. its registered copy) captures layer13_out into a staging register.
//     - ap_done=1: u_out<=staging (or layer13_out if the vld edge is in the same cycle), u_vld=1 next cycle, go to IDLE.
//     - wdog==TIMEOUT-1 with no ap_done: set timeout_flag, keep u_out unchanged, no u_vld, go to IDLE.
//     - A late ap_done in IDLE is ignored.
// - Overrun: a tick while state!=IDLE drops the sample, and overrun_cnt increments, saturating at 16'hFFFF.
//   A tick in the same cycle as ap_done counts as an overrun (state is still WAIT).
// - clr_flags=1 clears timeout_flag and overrun_cnt.
//   If an overrun or timeout event coincides with clr_flags, the event wins: count=1 / flag=1.
// - Latency: tick at cycle T -> ap_start at T+1 -> u_vld at (ap_done cycle)+1.
// - busy=1 exactly while state is LAUNCH or WAIT.
// CONFIGURATION
// - MOTOR_SEQ_CLAMP_EN defined:
//   - r/pos/vel are saturated to [-CLAMP, +CLAMP] (signed compare) at latch time.
//   - u_out is saturated to the same range at capture.
// - Not defined: values pass through unmodified; the CLAMP parameter is unused.
// TESTING
// - Reset then en=1, PERIOD=16: first ap_start at cycle 16 after en; 1-cycle pulse with fc0_input_ap_vld; r/pos/vel equal *_in sampled at the tick.
// - Model returns layer13_out=32'h0000_1234 with vld high 2 cycles, ap_done 6 cycles later -> u_out=32'h1234, single u_vld pulse, busy low after.
// - ap_done never arrives, TIMEOUT=10 -> timeout_flag=1 at WAIT cycle 10; u_out unchanged; next tick launches normally.
// - ap_done held off 20 cycles with PERIOD=16 -> overrun_cnt=1; only one ap_start across that window; clr_flags -> 0.
// - ap_rst_n=0 during WAIT -> all outputs 0 next cycle; later ap_done pulse produces no u_vld.
// - MOTOR_SEQ_CLAMP_EN, CLAMP=32'sh7FFF, pos_in=32'sh0001_0000, vel_in=-32'sh0001_0000 -> pos=32'sh7FFF, vel=-32'sh7FFF.

Source files
------------

// File: rtl/motor_step_sequencer.sv
// Periodic control-step launcher for motor_main: latches r/pos/vel, pulses start, captures the NN command, with watchdog and overrun count.
// Optional build macro MOTOR_SEQ_CLAMP_EN saturates latched inputs and the captured command to [-CLAMP, +CLAMP].
module motor_step_sequencer #(
    parameter int                    W       = 32,
    parameter int                    PERIOD  = 1000,
    parameter int                    TIMEOUT = 900,
    parameter logic signed [W-1:0]   CLAMP   = W'(32'sh0000_7FFF)
) (
    input  logic         clk_1,
    input  logic         ap_rst_n,
    input  logic         en,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] pos_in,
    input  logic [W-1:0] vel_in,
    output logic [W-1:0] r,
    output logic [W-1:0] pos,
    output logic [W-1:0] vel,
    output logic         ap_start,
    output logic         fc0_input_ap_vld,
    input  logic         ap_done,
    input  logic [W-1:0] layer13_out,
    input  logic         layer13_out_ap_vld,
    output logic [W-1:0] u_out,
    output logic         u_vld,
    output logic         busy,
    output logic         timeout_flag,
    output logic [15:0]  overrun_cnt,
    input  logic         clr_flags
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(PERIOD - 1);
    localparam logic [DW-1:0] WDOG_LAST = DW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

`ifdef MOTOR_SEQ_CLAMP_EN
    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        logic signed [W-1:0] s;
        s = signed'(v);
        if (s > CLAMP)  return CLAMP;
        if (s < -CLAMP) return -CLAMP;
        return v;
    endfunction
`else
    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        return v;
    endfunction

    logic unused_clamp;
    assign unused_clamp = ^CLAMP;
`endif

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] wdog;
    logic          tick;
    logic          vld_q;
    logic          vld_rise;
    logic          overrun;
    logic          do_latch;
    logic          do_capture;
    logic          do_abort;
    logic [W-1:0]  staging;
    logic [W-1:0]  cmd_next;

    assign tick     = en && (tcnt == TCNT_LAST);
    assign vld_rise = layer13_out_ap_vld && !vld_q;
    assign overrun  = tick && (state != IDLE);
    // A vld edge coincident with ap_done bypasses the staging register.
    assign cmd_next = vld_rise ? layer13_out : staging;

    always_ff @(posedge clk_1) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_next       = state;
        do_latch         = 1'b0;
        do_capture       = 1'b0;
        do_abort         = 1'b0;
        ap_start         = 1'b0;
        fc0_input_ap_vld = 1'b0;
        busy             = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    do_latch   = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                ap_start         = 1'b1;
                fc0_input_ap_vld = 1'b1;
                busy             = 1'b1;
                state_next       = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (ap_done) begin
                    do_capture = 1'b1;
                    state_next = IDLE;
                end else if (wdog == WDOG_LAST) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1) begin
        // NOTE: the datapath registers are reset as well, because every output must read 0 right after reset.
        if (!ap_rst_n) begin
            tcnt         <= '0;
            wdog         <= '0;
            vld_q        <= 1'b0;
            staging      <= '0;
            r            <= '0;
            pos          <= '0;
            vel          <= '0;
            u_out        <= '0;
            u_vld        <= 1'b0;
            timeout_flag <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            tcnt  <= (!en || tick) ? '0 : tcnt + TW'(1);
            wdog  <= (state == WAIT) ? wdog + DW'(1) : '0;
            vld_q <= layer13_out_ap_vld;

            if ((state == WAIT) && vld_rise) begin
                staging <= layer13_out;
            end

            if (do_latch) begin
                r   <= sat(r_in);
                pos <= sat(pos_in);
                vel <= sat(vel_in);
            end

            u_vld <= do_capture;
            if (do_capture) begin
                u_out <= sat(cmd_next);
            end

            // A watchdog abort or overrun in the same cycle as clr_flags takes priority over the clear.
            if (do_abort) begin
                timeout_flag <= 1'b1;
            end else if (clr_flags) begin
                timeout_flag <= 1'b0;
            end

            if (clr_flags) begin
                overrun_cnt <= {15'd0, overrun};
            end else if (overrun && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

endmodule
